regfile_read_port: RTL

- 32 x 64-bit architectural register file: one write port, two independent read ports.
- Supplies the operands for the datapath decode stage. Accepts the writeback result from the final stage.
- X31 (XZR) always reads as zero.
- Storage is clocked; reads are combinational from the stored state, so a write becomes visible on the following cycle unless bypass is compiled in.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/decoder_5to32.sv | 20 ++
 rtl/regfile_read_port.sv | 80 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing for the 32 x 64-bit architectural register file.
// Optional write-first read forwarding is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 31;
    localparam int ADDR_W   = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == reg_addr_t'(ZERO_REG);
    endfunction

endpackage

// File: rtl/decoder_5to32.sv
// Write-port address decoder: turns a register index plus enable into
// one-hot write strobes, all low when the enable is low.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic                enable,
    input  reg_addr_t           addr,
    output logic [NUM_REGS-1:0] strobe
);

    always_comb begin
        strobe = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (enable && addr == reg_addr_t'(i)) begin
                strobe[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// 32 x 64-bit register file, one write port and two combinational read ports.
// X31 reads zero; define REGFILE_BYPASS_EN for write-first read forwarding.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  reg_addr_t read_addr_a,
    input  reg_addr_t read_addr_b,
    output word_t     read_data_a,
    output word_t     read_data_b,
    input  logic      write_enable,
    input  reg_addr_t write_addr,
    input  word_t     write_data
);

    logic [NUM_REGS-1:0] strobe;
    word_t               regs [NUM_REGS];
    word_t               stored_a;
    word_t               stored_b;

    decoder_5to32 u_dec (
        .enable (write_enable),
        .addr   (write_addr),
        .strobe (strobe)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            // No storage: the zero register simply never takes a write.
            logic unused_strobe;
            assign unused_strobe = strobe[i];
            assign regs[i]       = '0;
        end else begin : g_store
            word_t q;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    q <= '0;
                end else if (strobe[i]) begin
                    q <= write_data;
                end
            end
            assign regs[i] = q;
        end
    end

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (read_addr_a == reg_addr_t'(i)) begin
                stored_a = regs[i];
            end
            if (read_addr_b == reg_addr_t'(i)) begin
                stored_b = regs[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;

    assign fwd_ok = write_enable && reset && !is_zero_reg(write_addr);

    always_comb begin
        read_data_a = stored_a;
        read_data_b = stored_b;
        if (fwd_ok && write_addr == read_addr_a) begin
            read_data_a = write_data;
        end
        if (fwd_ok && write_addr == read_addr_b) begin
            read_data_b = write_data;
        end
    end
`else
    assign read_data_a = stored_a;
    assign read_data_b = stored_b;
`endif

endmodule
